udp_rx_word_packer: RTL and testbench



---
 rtl/eth_pkg.sv | 14 +
 rtl/udp_rx_word_packer_if.sv | 22 ++
 rtl/byte_lane_packer.sv | 41 ++++
 rtl/udp_rx_word_packer.sv | 84 ++++++++
 tb/tb_udp_rx_word_packer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared constants and state encoding for the UDP receive word packer
package eth_pkg;
  localparam int UDP_HDR_LEN = 8;
  localparam int MAX_WORDS = 120;
  localparam int CNT_W = 7;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PACK = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  function automatic logic [15:0] payload_len(input logic [15:0] len);
    return len < 16'(UDP_HDR_LEN) ? 16'd0 : len - 16'(UDP_HDR_LEN);
  endfunction
endpackage

// File: rtl/udp_rx_word_packer_if.sv
// udp_rx_word_packer_if: payload byte stream in, FIFO write port and frame status out
interface udp_rx_word_packer_if;
  logic udp_rec_data_valid;
  logic [7:0] udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic fifo_full;
  logic clr_overflow;
  logic wr_en;
  logic [31:0] wr_data;
  logic frame_done;
  logic [eth_pkg::CNT_W-1:0] frame_words;
  logic len_err;
  logic overflow;
  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, fifo_full, clr_overflow,
    input wr_en, wr_data, frame_done, frame_words, len_err, overflow
  );
  modport slave (
    input udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, fifo_full, clr_overflow,
    output wr_en, wr_data, frame_done, frame_words, len_err, overflow
  );
endinterface

// File: rtl/byte_lane_packer.sv
// byte_lane_packer: big-endian 4-lane byte accumulator with zero-filled word output
module byte_lane_packer (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        push_i,
  input  logic        last_i,
  input  logic        flush_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        rdy_o
);
  logic [31:0] acc_q, acc_d, word_q, word_d, ins;
  logic [1:0] lane_q, lane_d;
  logic rdy_q, rdy_d, full, part;
  // insert the byte at its lane; a completed or flushed word leaves the accumulator empty (all zero)
  always_comb begin
    ins = acc_q | ({24'd0, byte_i} << {~lane_q, 3'b000});
    full = push_i && (last_i || lane_q == 2'd3);
    part = flush_i && lane_q != 2'd0;
    rdy_d = full || part;
    word_d = full ? ins : part ? acc_q : word_q;
    acc_d = (full || flush_i) ? '0 : push_i ? ins : acc_q;
    lane_d = (full || flush_i) ? '0 : push_i ? lane_q + 2'd1 : lane_q;
  end
  // lane registers; rdy is a one-cycle word-ready pulse
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      acc_q <= '0;
      word_q <= '0;
      lane_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      word_q <= word_d;
      lane_q <= lane_d;
      rdy_q <= rdy_d;
    end
  end
  assign word_o = word_q;
  assign rdy_o = rdy_q;
endmodule

// File: rtl/udp_rx_word_packer.sv
// udp_rx_word_packer: packs UDP payload bytes into 32-bit FIFO words and reports per-frame status
module udp_rx_word_packer import eth_pkg::*; (
  input logic rgmii_clk,
  input logic rstn,
  udp_rx_word_packer_if.slave bus
);
  logic [2:0] state_q, state_d;
  logic [15:0] exp_q, exp_d, cnt_q, cnt_d, cap;
  logic [CNT_W-1:0] iss_q, iss_d, wcnt_q, wcnt_d, fw_q, fw_d;
  logic err_q, err_d, done_q, done_d, lerr_q, lerr_d, ovf_q, ovf_d;
  logic v, start, push, last, flush, rdy, lim, wr, drop;
  logic [31:0] word;
  assign v = bus.udp_rec_data_valid;
  assign cap = payload_len(bus.udp_rec_data_length);
  assign start = state_q == ST_IDLE && v;
  assign lim = iss_q == CNT_W'(MAX_WORDS);
  assign wr = rdy && !lim && !bus.fifo_full;
  assign drop = rdy && !lim && bus.fifo_full;
  byte_lane_packer u_lanes (
    .clk_i(rgmii_clk), .rstn_i(rstn), .push_i(push), .last_i(last), .flush_i(flush),
    .byte_i(bus.udp_rec_rdata), .word_o(word), .rdy_o(rdy)
  );
  // state register
  always_ff @(posedge rgmii_clk) state_q <= !rstn ? ST_IDLE : state_d;
  // next state; a first byte with exp<=1 completes (or overruns) the frame immediately
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = !v ? ST_IDLE : cap <= 16'd1 ? ST_DONE : ST_PACK;
      ST_PACK: state_d = !v ? ST_FLUSH : last ? ST_DONE : ST_PACK;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE, ST_DRAIN: state_d = v ? ST_DRAIN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // lane packer controls decoded from state
  always_comb begin
    push = v && (start ? cap != 16'd0 : state_q == ST_PACK);
    last = start ? cap == 16'd1 : cnt_q + 16'd1 == exp_q;
    flush = state_q == ST_FLUSH;
  end
  // frame counters, word limit and FIFO gating; results latch when leaving DONE
  always_comb begin
    exp_d = start ? cap : exp_q;
    cnt_d = start ? 16'd1 : push ? cnt_q + 16'd1 : cnt_q;
    iss_d = start ? '0 : (rdy && !lim) ? iss_q + CNT_W'(1) : iss_q;
    wcnt_d = start ? '0 : wcnt_q + CNT_W'(wr);
    err_d = start ? cap == 16'd0 : err_q || flush || (rdy && lim);
    done_d = state_q == ST_DONE;
    lerr_d = done_d && (err_q || v || (rdy && lim));
    fw_d = done_d ? wcnt_q + CNT_W'(wr) : fw_q;
    ovf_d = drop || (ovf_q && !bus.clr_overflow);
  end
  // datapath registers
  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      exp_q <= '0;
      cnt_q <= '0;
      iss_q <= '0;
      wcnt_q <= '0;
      fw_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      lerr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      cnt_q <= cnt_d;
      iss_q <= iss_d;
      wcnt_q <= wcnt_d;
      fw_q <= fw_d;
      err_q <= err_d;
      done_q <= done_d;
      lerr_q <= lerr_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.wr_en = wr;
  assign bus.wr_data = word;
  assign bus.frame_done = done_q;
  assign bus.frame_words = fw_q;
  assign bus.len_err = lerr_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_udp_rx_word_packer.sv
// tb_udp_rx_word_packer: directed frames with hand-computed words and frame status
module tb_udp_rx_word_packer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0, total = 0, bad = 0, fd_n = 0, le_n = 0, le_seen = 0;
  logic [6:0] fd_words = '0;
  logic fd_err = 1'b0;
  logic [31:0] wq[$];
  int wc[$];
  int bcyc[16];
  udp_rx_word_packer_if bus();
  udp_rx_word_packer dut (.rgmii_clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // record writes and frame status away from the active edge
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq.push_back(bus.wr_data);
      wc.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) begin
      fd_n = fd_n + 1;
      fd_words = bus.frame_words;
      fd_err = bus.len_err;
    end
    if (bus.len_err === 1'b1) le_n = le_n + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask
  task automatic frame(input logic [15:0] len, input logic [7:0] b0, input int n, input int ff);
    int f0, l0;
    f0 = fd_n;
    l0 = le_n;
    wq.delete();
    wc.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.udp_rec_data_valid = 1'b1;
      bus.udp_rec_rdata = b0 + 8'(i);
      bus.udp_rec_data_length = len;
      bus.fifo_full = (i == ff);
      bcyc[i] = cyc;
    end
    @(posedge clk); #1;
    bus.udp_rec_data_valid = 1'b0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 20 && fd_n == f0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("frame_done_count", 32'(fd_n - f0), 32'd1);
    le_seen = le_n - l0;
  endtask
  initial begin
    bus.udp_rec_data_valid = 1'b0;
    bus.udp_rec_rdata = '0;
    bus.udp_rec_data_length = '0;
    bus.fifo_full = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_frame_words", 32'(bus.frame_words), 0);
    chk("rst_len_err", 32'(bus.len_err), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    frame(16'd16, 8'h01, 8, -1);
    chk("t1_nwr", 32'(wq.size()), 2);
    chk("t1_w0", wq[0], 32'h01020304);
    chk("t1_w1", wq[1], 32'h05060708);
    chk("t1_lat0", 32'(wc[0]), 32'(bcyc[3] + 1));
    chk("t1_lat1", 32'(wc[1]), 32'(bcyc[7] + 1));
    chk("t1_words", 32'(fd_words), 2);
    chk("t1_err", 32'(le_seen), 0);
    frame(16'd14, 8'hAA, 6, -1);
    chk("t2_nwr", 32'(wq.size()), 2);
    chk("t2_w0", wq[0], 32'hAAABACAD);
    chk("t2_w1", wq[1], 32'hAEAF0000);
    chk("t2_words", 32'(fd_words), 2);
    chk("t2_err", 32'(le_seen), 0);
    frame(16'd20, 8'h11, 5, -1);
    chk("t3_nwr", 32'(wq.size()), 2);
    chk("t3_w0", wq[0], 32'h11121314);
    chk("t3_w1", wq[1], 32'h15000000);
    chk("t3_words", 32'(fd_words), 2);
    chk("t3_err_at_done", 32'(fd_err), 1);
    frame(16'd12, 8'h21, 7, -1);
    chk("t4_nwr", 32'(wq.size()), 1);
    chk("t4_w0", wq[0], 32'h21222324);
    chk("t4_words", 32'(fd_words), 1);
    chk("t4_err_at_done", 32'(fd_err), 1);
    chk("t4_err_pulses", 32'(le_seen), 1);
    frame(16'd9, 8'h77, 1, -1);
    chk("exp1_nwr", 32'(wq.size()), 1);
    chk("exp1_w0", wq[0], 32'h77000000);
    chk("exp1_words", 32'(fd_words), 1);
    chk("exp1_err", 32'(le_seen), 0);
    frame(16'd4, 8'h55, 1, -1);
    chk("exp0_nwr", 32'(wq.size()), 0);
    chk("exp0_words", 32'(fd_words), 0);
    chk("exp0_err_at_done", 32'(fd_err), 1);
    frame(16'd20, 8'h31, 12, 8);
    chk("t5_nwr", 32'(wq.size()), 2);
    chk("t5_w0", wq[0], 32'h31323334);
    chk("t5_w1", wq[1], 32'h393A3B3C);
    chk("t5_words", 32'(fd_words), 2);
    chk("t5_err", 32'(le_seen), 0);
    chk("t5_ovf_sticky", 32'(bus.overflow), 1);
    @(posedge clk); #1;
    bus.clr_overflow = 1'b1;
    @(posedge clk); #1;
    bus.clr_overflow = 1'b0;
    @(negedge clk);
    chk("t5_ovf_clr", 32'(bus.overflow), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.udp_rec_data_valid = 1'b1;
      bus.udp_rec_rdata = 8'h51 + 8'(i);
      bus.udp_rec_data_length = 16'd16;
      bus.fifo_full = (i == 4);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.udp_rec_data_valid = 1'b0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    chk("t6_ovf_pre", 32'(bus.overflow), 1);
    @(posedge clk);
    @(negedge clk);
    chk("t6_wr_en", 32'(bus.wr_en), 0);
    chk("t6_wr_data", bus.wr_data, 0);
    chk("t6_frame_done", 32'(bus.frame_done), 0);
    chk("t6_frame_words", 32'(bus.frame_words), 0);
    chk("t6_len_err", 32'(bus.len_err), 0);
    chk("t6_overflow", 32'(bus.overflow), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    frame(16'd12, 8'h41, 4, -1);
    chk("t6_nwr", 32'(wq.size()), 1);
    chk("t6_w0", wq[0], 32'h41424344);
    chk("t6_words", 32'(fd_words), 1);
    chk("t6_err", 32'(le_seen), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
